// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and ALU-drive bundle for alu_cmd_sequencer.
// The sequencer takes the slave view; the command/response agent takes the master view.
interface alu_cmd_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_ra;
    logic [AW-1:0] cmd_rb;
    logic [AW-1:0] cmd_rd;
    logic [DW-1:0] cmd_imm;
    logic [DW-1:0] alu_din1;
    logic [DW-1:0] alu_din2;
    logic [2:0]    alu_ms;
    logic [DW-1:0] alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm, alu_result, rsp_ready,
        output cmd_ready, alu_din1, alu_din2, alu_ms, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm, alu_result, rsp_ready,
        input  cmd_ready, alu_din1, alu_din2, alu_ms, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Register-file command sequencer driving a combinational 16-bit ALU for one cycle per op,
// with divide/modulo-by-zero trapped before the ALU is ever asked.
module alu_cmd_sequencer #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_cmd_sequencer_if.slave    bus,
    output logic [7:0]            err_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] rf [NREG];
    logic [AW-1:0] rd_q;

    logic          accept;
    logic [DW-1:0] opa, opb;
    logic          is_load, zero_div;

    assign accept   = bus.cmd_valid & bus.cmd_ready;
    assign opa      = rf[bus.cmd_ra];
    assign opb      = rf[bus.cmd_rb];
    assign is_load  = (bus.cmd_op == 3'b000);
    assign zero_div = ((bus.cmd_op == 3'b100) || (bus.cmd_op == 3'b110)) && (opb == '0);

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (is_load || zero_div) ? RESP : EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Trapped div/mod never reach the ALU: alu_ms only ever carries ops that go through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            rd_q         <= '0;
            bus.alu_din1 <= '0;
            bus.alu_din2 <= '0;
            bus.alu_ms   <= '0;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
            err_cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rd_q <= bus.cmd_rd;
                    if (is_load) begin
                        rf[bus.cmd_rd] <= bus.cmd_imm;
                        bus.rsp_data   <= bus.cmd_imm;
                        bus.rsp_err    <= 1'b0;
                    end else if (zero_div) begin
                        bus.rsp_data <= '1;
                        bus.rsp_err  <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end else begin
                        bus.alu_din1 <= opa;
                        bus.alu_din2 <= opb;
                        bus.alu_ms   <= bus.cmd_op;
                    end
                end
                EXEC: begin
                    rf[rd_q]     <= bus.alu_result;
                    bus.rsp_data <= bus.alu_result;
                    bus.rsp_err  <= 1'b0;
                    bus.alu_ms   <= 3'b000;
                end
                RESP: if (bus.rsp_ready) bus.rsp_err <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU on the far side of the bus.
module tb_alu_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] err_cnt;
    int         n_chk = 0;
    int         n_pass = 0;
    logic       mon_en = 1'b0;
    logic       ms4_seen = 1'b0;

    alu_cmd_sequencer_if #(.DW(16), .AW(3)) bus ();

    alu_cmd_sequencer #(.DW(16), .NREG(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Reference ALU: 001 add, 010 sub, 011 mul, 100 div, 110 mod, anything else 0.
    always_comb begin
        bus.alu_result = 16'h0000;
        case (bus.alu_ms)
            3'b001: bus.alu_result = bus.alu_din1 + bus.alu_din2;
            3'b010: bus.alu_result = bus.alu_din1 - bus.alu_din2;
            3'b011: bus.alu_result = bus.alu_din1 * bus.alu_din2;
            3'b100: bus.alu_result = (bus.alu_din2 == 0) ? 16'h0 : bus.alu_din1 / bus.alu_din2;
            3'b110: bus.alu_result = (bus.alu_din2 == 0) ? 16'h0 : bus.alu_din1 % bus.alu_din2;
            default: bus.alu_result = 16'h0000;
        endcase
    end

    always @(negedge clk) if (mon_en && bus.alu_ms == 3'b100) ms4_seen <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd, input logic [15:0] imm,
                         output logic [15:0] data, output logic err, output int lat);
        bit got = 0;
        @(negedge clk);
        bus.cmd_op = op; bus.cmd_ra = ra; bus.cmd_rb = rb; bus.cmd_rd = rd; bus.cmd_imm = imm;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        data = '0; err = 1'b0; lat = 0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                data = bus.rsp_data; err = bus.rsp_err; lat = i; got = 1;
            end
        end
        if (!got) chk("rsp_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [2:0] rd, input logic [15:0] imm);
        logic [15:0] d; logic e; int l;
        issue(3'b000, 3'd0, 3'd0, rd, imm, d, e, l);
    endtask

    // r0 is kept at zero so rX + r0 reads a register back without changing it.
    task automatic rdreg(input logic [2:0] r, output logic [15:0] v);
        logic e; int l;
        issue(3'b001, r, 3'd0, r, 16'h0, v, e, l);
    endtask

    initial begin
        logic [15:0] d;
        logic        e;
        int          lat;
        bus.cmd_valid = 0; bus.rsp_ready = 0; bus.cmd_op = 0;
        bus.cmd_ra = 0; bus.cmd_rb = 0; bus.cmd_rd = 0; bus.cmd_imm = 0;

        // 1: reset state and basic add
        #12;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_alu_ms", bus.alu_ms, 0);
        chk("rst_din1", bus.alu_din1, 0);
        @(negedge clk); rst_n = 1'b1;

        issue(3'b000, 0, 0, 3'd1, 16'd7, d, e, lat);
        chk("load_data", d, 7);
        chk("load_lat", lat, 1);
        load(3'd2, 16'd3);
        issue(3'b001, 3'd1, 3'd2, 3'd3, 16'h0, d, e, lat);
        chk("add_data", d, 10);
        chk("add_err", e, 0);
        chk("add_lat", lat, 2);
        chk("idle_after_rsp", bus.cmd_ready, 1);
        rdreg(3'd3, d);
        chk("rf3_add", d, 10);

        // 2: sub wrap, mul truncation, same-register op, unsigned div/mod
        load(3'd1, 16'd3); load(3'd2, 16'd7);
        issue(3'b010, 3'd1, 3'd2, 3'd4, 16'h0, d, e, lat);
        chk("sub_wrap", d, 16'hFFFC);
        load(3'd1, 16'h0100); load(3'd2, 16'h0100);
        issue(3'b011, 3'd1, 3'd2, 3'd5, 16'h0, d, e, lat);
        chk("mul_trunc", d, 16'h0000);
        load(3'd6, 16'd5);
        issue(3'b001, 3'd6, 3'd6, 3'd6, 16'h0, d, e, lat);
        chk("add_same_reg", d, 10);
        load(3'd1, 16'hFFF0); load(3'd2, 16'd7);
        issue(3'b100, 3'd1, 3'd2, 3'd4, 16'h0, d, e, lat);
        chk("div_unsigned", d, 16'd9360);
        issue(3'b110, 3'd1, 3'd2, 3'd4, 16'h0, d, e, lat);
        chk("mod_unsigned", d, 16'd0);

        // 3: divide / modulo by zero trapped
        load(3'd2, 16'h0); load(3'd6, 16'h1234);
        mon_en = 1'b1;
        issue(3'b100, 3'd1, 3'd2, 3'd6, 16'h0, d, e, lat);
        chk("div0_err", e, 1);
        chk("div0_data", d, 16'hFFFF);
        chk("div0_lat", lat, 1);
        issue(3'b110, 3'd1, 3'd2, 3'd6, 16'h0, d, e, lat);
        chk("mod0_err", e, 1);
        chk("mod0_data", d, 16'hFFFF);
        chk("err_cnt_2", err_cnt, 2);
        chk("err_cleared", bus.rsp_err, 0);
        mon_en = 1'b0;
        chk("ms_no_div", ms4_seen, 0);
        rdreg(3'd6, d);
        chk("rd_unchanged", d, 16'h1234);

        // 4: response back-pressure
        load(3'd1, 16'd1); load(3'd2, 16'd2);
        @(negedge clk);
        bus.cmd_op = 3'b001; bus.cmd_ra = 3'd1; bus.cmd_rb = 3'd2; bus.cmd_rd = 3'd3;
        bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.cmd_op = 3'b000; bus.cmd_rd = 3'd7; bus.cmd_imm = 16'hAAAA;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_data", bus.rsp_data, 3);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
        end
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_idle", bus.cmd_ready, 1);
        chk("bp_release_valid", bus.rsp_valid, 0);
        rdreg(3'd7, d);
        chk("bp_no_accept", d, 0);

        // 5: reset during EXEC
        load(3'd1, 16'd5); load(3'd2, 16'd6);
        @(negedge clk);
        bus.cmd_op = 3'b001; bus.cmd_ra = 3'd1; bus.cmd_rb = 3'd2; bus.cmd_rd = 3'd3;
        bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("exec_ms", bus.alu_ms, 3'b001);
        rst_n = 1'b0; #1;
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
        chk("mid_rst_ms", bus.alu_ms, 0);
        chk("mid_rst_din1", bus.alu_din1, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_data", bus.rsp_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (bus.rsp_valid) seen = 1'b1;
            end
            chk("no_rsp_after_rst", seen, 0);
        end
        for (int r = 1; r < 8; r++) begin
            rdreg(r[2:0], d);
            chk("rf_cleared", d, 0);
        end

        // 6: error counter saturation (r2 is 0 after reset)
        for (int i = 0; i < 254; i++) issue(3'b100, 3'd1, 3'd2, 3'd4, 16'h0, d, e, lat);
        chk("err_cnt_254", err_cnt, 254);
        for (int i = 0; i < 46; i++) issue(3'b110, 3'd1, 3'd2, 3'd4, 16'h0, d, e, lat);
        chk("err_cnt_sat", err_cnt, 255);
        chk("sat_rsp_err", e, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
